// File: rtl/ccip_flow_batch_tx.sv
// Per-flow RPC buffering with batched WRLINE_I writes on CCI-P c1.
// Round-robin flow service, timeout flush, drop/flush statistics.

package ccip_tx_pkg;
   typedef logic [41:0]  t_ccip_clAddr;
   typedef logic [511:0] t_ccip_clData;

   typedef enum logic [1:0] {
      eVC_VA  = 2'd0,
      eVC_VL0 = 2'd1,
      eVC_VH0 = 2'd2,
      eVC_VH1 = 2'd3
   } t_ccip_vc;

   typedef enum logic [1:0] {
      eCL_LEN_1 = 2'd0,
      eCL_LEN_2 = 2'd1,
      eCL_LEN_4 = 2'd3
   } t_ccip_clLen;

   typedef enum logic [3:0] {
      eREQ_WRLINE_I = 4'h0,
      eREQ_WRLINE_M = 4'h1,
      eREQ_WRPUSH_I = 4'h2,
      eREQ_WRFENCE  = 4'h4,
      eREQ_INTR     = 4'h6
   } t_ccip_c1_req;

   typedef struct packed {
      logic [5:0]   rsvd2;
      t_ccip_vc     vc_sel;
      logic         sop;
      logic         rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      logic [15:0]  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic               valid;
      t_ccip_clData       data;
   } t_if_ccip_c1_Tx;
endpackage

module ccip_flow_batch_tx
   import ccip_tx_pkg::*;
#(
   parameter int NIC_ID            = 0,
   parameter int LMAX_NUM_OF_FLOWS = 2,
   parameter int LFIFO_DEPTH       = 3,
   parameter int LMAX_BATCH        = 2,
   parameter int DATA_WIDTH        = 512
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [LMAX_NUM_OF_FLOWS-1:0]          number_of_flows,
   input  logic [$bits(t_ccip_clAddr)-1:0]       tx_base_addr,
   input  logic [1:0]                            l_tx_batch_size,
   input  logic [15:0]                           flush_timeout,
   input  logic                                  start,
   input  logic                                  sRx_c1TxAlmFull,
   output logic [$bits(t_if_ccip_c1_Tx)-1:0]     sTx_c1,
   output logic                                  ccip_tx_ready,
   input  logic [DATA_WIDTH-1:0]                 data_in,
   input  logic                                  data_valid_in,
   input  logic [LMAX_NUM_OF_FLOWS-1:0]          flow_id_in,
   output logic [(2**LMAX_NUM_OF_FLOWS)-1:0]     flow_full_out,
   output logic [31:0]                           pdrop_cnt_out,
   output logic [31:0]                           flush_cnt_out
);

   localparam int F         = LMAX_NUM_OF_FLOWS;
   localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
   localparam int DEPTH     = 2**LFIFO_DEPTH;
   localparam int CW        = LFIFO_DEPTH + 1;

   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t       DEPTH_C = cnt_t'(DEPTH);
   localparam logic [1:0] LMAX_B  = 2'(LMAX_BATCH);

   typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

   if (LFIFO_DEPTH < LMAX_BATCH || LMAX_BATCH > 2 ||
       DATA_WIDTH > 512 || NIC_ID < 0) begin : g_bad_cfg
      $error("ccip_flow_batch_tx %0d: bad parameters", NIC_ID);
   end

   logic [DATA_WIDTH-1:0]  mem [MAX_FLOWS][DEPTH];
   logic [LFIFO_DEPTH-1:0] wr_ptr [MAX_FLOWS];
   logic [LFIFO_DEPTH-1:0] rd_ptr [MAX_FLOWS];
   cnt_t                   cnt [MAX_FLOWS];
   cnt_t                   cnt_nxt [MAX_FLOWS];
   logic [15:0]            timer [MAX_FLOWS];
   logic [MAX_FLOWS-1:0]   push_v, pop_v, start_v;

   state_t         state;
   logic [F-1:0]   ptr, ptr_adv, cur_flow;
   logic [1:0]     lb, cur_lb;
   cnt_t           bsz, n_beats, beat;
   logic           push, drop, pop, go_send, go_flush;
   t_if_ccip_c1_Tx tx_q, beat_tx;

   assign lb       = (l_tx_batch_size > LMAX_B) ? LMAX_B : l_tx_batch_size;
   assign bsz      = cnt_t'(1) << lb;
   assign push     = data_valid_in & start & ~flow_full_out[flow_id_in];
   assign drop     = data_valid_in & start & flow_full_out[flow_id_in];
   assign pop      = (state != IDLE) & ~sRx_c1TxAlmFull;
   assign go_send  = (state == IDLE) && (cnt[ptr] >= bsz);
   assign go_flush = (state == IDLE) && !go_send &&
                     (flush_timeout != 16'd0) && (cnt[ptr] != '0) &&
                     (timer[ptr] >= flush_timeout);
   assign ptr_adv  = (ptr >= number_of_flows) ? '0 : ptr + 1'b1;

   assign ccip_tx_ready = ~sRx_c1TxAlmFull;
   assign sTx_c1        = tx_q;

   // Per-flow push/pop decode and next occupancy
   always_comb begin
      push_v  = '0;
      pop_v   = '0;
      start_v = '0;
      for (int f = 0; f < MAX_FLOWS; f++) begin
         push_v[f]  = push && (flow_id_in == F'(f));
         pop_v[f]   = pop && (cur_flow == F'(f));
         start_v[f] = (go_send || go_flush) && (ptr == F'(f));
         cnt_nxt[f] = cnt[f] + cnt_t'(push_v[f]) - cnt_t'(pop_v[f]);
      end
   end

   // Payload storage, written on accepted pushes
   always_ff @(posedge clk) begin
      if (push)
         mem[flow_id_in][wr_ptr[flow_id_in]] <= data_in;
   end

   // FIFO pointers, occupancy, full flags, idle timers, drop counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int f = 0; f < MAX_FLOWS; f++) begin
            wr_ptr[f] <= '0;
            rd_ptr[f] <= '0;
            cnt[f]    <= '0;
            timer[f]  <= '0;
         end
         flow_full_out <= '0;
         pdrop_cnt_out <= '0;
      end else begin
         for (int f = 0; f < MAX_FLOWS; f++) begin
            if (push_v[f])
               wr_ptr[f] <= wr_ptr[f] + 1'b1;
            if (pop_v[f])
               rd_ptr[f] <= rd_ptr[f] + 1'b1;
            cnt[f]           <= cnt_nxt[f];
            flow_full_out[f] <= (cnt_nxt[f] == DEPTH_C);
            if (push_v[f] || cnt[f] == '0 || start_v[f])
               timer[f] <= '0;
            else if (timer[f] != 16'hFFFF)
               timer[f] <= timer[f] + 1'b1;
         end
         if (drop && pdrop_cnt_out != 32'hFFFF_FFFF)
            pdrop_cnt_out <= pdrop_cnt_out + 1'b1;
      end
   end

   // Request beat built from the head of the flow being served
   always_comb begin
      beat_tx                  = '0;
      beat_tx.valid            = 1'b1;
      beat_tx.hdr.vc_sel       = eVC_VH0;
      beat_tx.hdr.req_type     = eREQ_WRLINE_I;
      beat_tx.hdr.address      = t_ccip_clAddr'(tx_base_addr) +
                                 (t_ccip_clAddr'(cur_flow) << cur_lb) +
                                 t_ccip_clAddr'(beat);
      beat_tx.data[DATA_WIDTH-1:0] = mem[cur_flow][rd_ptr[cur_flow]];
      if (state == FLUSH) begin
         beat_tx.hdr.cl_len = eCL_LEN_1;
         beat_tx.hdr.sop    = 1'b1;
      end else begin
         beat_tx.hdr.sop = (beat == '0);
         unique case (1'b1)
            cur_lb == 2'd0: beat_tx.hdr.cl_len = eCL_LEN_1;
            cur_lb == 2'd1: beat_tx.hdr.cl_len = eCL_LEN_2;
            default:        beat_tx.hdr.cl_len = eCL_LEN_4;
         endcase
      end
   end

   // Scheduler FSM: round-robin scan, batch/flush issue, registered c1 output
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         ptr           <= '0;
         cur_flow      <= '0;
         cur_lb        <= '0;
         n_beats       <= '0;
         beat          <= '0;
         tx_q          <= '0;
         flush_cnt_out <= '0;
      end else begin
         tx_q.valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (go_send) begin
                  state    <= SEND;
                  cur_flow <= ptr;
                  cur_lb   <= lb;
                  n_beats  <= bsz;
                  beat     <= '0;
               end else if (go_flush) begin
                  state    <= FLUSH;
                  cur_flow <= ptr;
                  cur_lb   <= lb;
                  n_beats  <= cnt[ptr];
                  beat     <= '0;
                  if (flush_cnt_out != 32'hFFFF_FFFF)
                     flush_cnt_out <= flush_cnt_out + 1'b1;
               end else begin
                  ptr <= ptr_adv;
               end
            end
            SEND, FLUSH: begin
               if (pop) begin
                  tx_q <= beat_tx;
                  beat <= beat + 1'b1;
                  if (beat == n_beats - 1'b1) begin
                     state <= IDLE;
                     ptr   <= ptr_adv;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccip_flow_batch_tx.sv
// Directed bench for ccip_flow_batch_tx.
// Hand-computed beats, addresses, counters and stall/reset behaviour.

module tb_ccip_flow_batch_tx;
   import ccip_tx_pkg::*;

   logic                                clk = 1'b0;
   logic                                reset_n;
   logic [1:0]                          number_of_flows;
   logic [41:0]                         tx_base_addr;
   logic [1:0]                          l_tx_batch_size;
   logic [15:0]                         flush_timeout;
   logic                                start;
   logic                                sRx_c1TxAlmFull;
   logic [$bits(t_if_ccip_c1_Tx)-1:0]   sTx_c1;
   logic                                ccip_tx_ready;
   logic [511:0]                        data_in;
   logic                                data_valid_in;
   logic [1:0]                          flow_id_in;
   logic [3:0]                          flow_full_out;
   logic [31:0]                         pdrop_cnt_out;
   logic [31:0]                         flush_cnt_out;

   t_if_ccip_c1_Tx tx;
   assign tx = sTx_c1;

   int n_cmp = 0;
   int n_bad = 0;

   localparam t_ccip_clAddr BASE = 42'h1000;

   int ef [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
   int ei [8] = '{0, 1, 0, 1, 2, 3, 2, 3};

   ccip_flow_batch_tx dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .number_of_flows (number_of_flows),
      .tx_base_addr    (tx_base_addr),
      .l_tx_batch_size (l_tx_batch_size),
      .flush_timeout   (flush_timeout),
      .start           (start),
      .sRx_c1TxAlmFull (sRx_c1TxAlmFull),
      .sTx_c1          (sTx_c1),
      .ccip_tx_ready   (ccip_tx_ready),
      .data_in         (data_in),
      .data_valid_in   (data_valid_in),
      .flow_id_in      (flow_id_in),
      .flow_full_out   (flow_full_out),
      .pdrop_cnt_out   (pdrop_cnt_out),
      .flush_cnt_out   (flush_cnt_out)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] pay(input int k);
      logic [31:0] w;
      w = k;
      return {16{w}};
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] f, input logic [511:0] d);
      flow_id_in    = f;
      data_in       = d;
      data_valid_in = 1'b1;
      step();
      data_valid_in = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int maxc,
                             output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!tx.valid && cyc < maxc);
      chk({tag, "_arrive"}, tx.valid, 1'b1);
   endtask

   task automatic chk_beat(input string tag, input t_ccip_clAddr a,
                           input t_ccip_clLen len, input logic sop,
                           input logic [511:0] d);
      chk({tag, "_valid"}, tx.valid, 1'b1);
      chk({tag, "_addr"}, tx.hdr.address, a);
      chk({tag, "_len"}, tx.hdr.cl_len, len);
      chk({tag, "_sop"}, tx.hdr.sop, sop);
      chk({tag, "_type"}, tx.hdr.req_type, eREQ_WRLINE_I);
      chk({tag, "_vc"}, tx.hdr.vc_sel, eVC_VH0);
      chk({tag, "_data"}, tx.data, d);
   endtask

   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk(tag, tx.valid, 1'b0);
      end
   endtask

   initial begin
      int cyc;
      int k;
      int fl;
      int ix;

      reset_n         = 1'b0;
      number_of_flows = 2'd1;
      tx_base_addr    = BASE;
      l_tx_batch_size = 2'd1;
      flush_timeout   = 16'd0;
      start           = 1'b1;
      sRx_c1TxAlmFull = 1'b1;
      data_in         = '0;
      data_valid_in   = 1'b0;
      flow_id_in      = 2'd0;

      // reset state
      repeat (3) step();
      chk("rst_valid", tx.valid, 1'b0);
      chk("rst_hdr", tx.hdr, '0);
      chk("rst_data", tx.data, '0);
      chk("rst_full", flow_full_out, 4'b0000);
      chk("rst_pdrop", pdrop_cnt_out, 32'd0);
      chk("rst_flush", flush_cnt_out, 32'd0);
      chk("rdy_stall", ccip_tx_ready, 1'b0);
      sRx_c1TxAlmFull = 1'b0;
      #1;
      chk("rdy_open", ccip_tx_ready, 1'b1);
      reset_n = 1'b1;
      step();

      // lb=1, two pushes to flow 1
      push(2'd1, pay(32'hA1));
      push(2'd1, pay(32'hA2));
      wait_valid("t1", 12, cyc);
      chk_beat("t1_b0", BASE + 42'h2, eCL_LEN_2, 1'b1, pay(32'hA1));
      step();
      chk_beat("t1_b1", BASE + 42'h3, eCL_LEN_2, 1'b0, pay(32'hA2));
      quiet("t1_idle", 4);

      // lb=2, stall mid-batch on flow 3
      l_tx_batch_size = 2'd2;
      number_of_flows = 2'd3;
      for (int i = 0; i < 4; i++) push(2'd3, pay(32'hB0 + i));
      wait_valid("t2", 12, cyc);
      chk_beat("t2_b0", BASE + 42'hC, eCL_LEN_4, 1'b1, pay(32'hB0));
      sRx_c1TxAlmFull = 1'b1;
      #1;
      chk("t2_rdy", ccip_tx_ready, 1'b0);
      quiet("t2_stall", 3);
      sRx_c1TxAlmFull = 1'b0;
      step();
      chk_beat("t2_b1", BASE + 42'hD, eCL_LEN_4, 1'b0, pay(32'hB1));
      step();
      chk_beat("t2_b2", BASE + 42'hE, eCL_LEN_4, 1'b0, pay(32'hB2));
      step();
      chk_beat("t2_b3", BASE + 42'hF, eCL_LEN_4, 1'b0, pay(32'hB3));
      quiet("t2_idle", 3);

      // timeout flush of a single CL on flow 0
      flush_timeout = 16'd10;
      push(2'd0, pay(32'hC0));
      wait_valid("t3", 25, cyc);
      chk("t3_lat_ok", (cyc >= 11 && cyc <= 16), 1'b1);
      chk_beat("t3_b0", BASE, eCL_LEN_1, 1'b1, pay(32'hC0));
      chk("t3_flush_cnt", flush_cnt_out, 32'd1);
      flush_timeout = 16'd0;
      quiet("t3_idle", 3);

      // fill flow 2 while stalled, two drops, then drain in order
      sRx_c1TxAlmFull = 1'b1;
      for (int i = 0; i < 10; i++) push(2'd2, pay(32'hD0 + i));
      start = 1'b0;
      push(2'd2, pay(32'hDF));
      start = 1'b1;
      chk("t4_full", flow_full_out, 4'b0100);
      chk("t4_pdrop", pdrop_cnt_out, 32'd2);
      chk("t4_stalled", tx.valid, 1'b0);
      sRx_c1TxAlmFull = 1'b0;
      k = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (tx.valid) begin
            if (k < 8)
               chk_beat($sformatf("t4_b%0d", k),
                        BASE + 42'h8 + t_ccip_clAddr'(k % 4), eCL_LEN_4,
                        (k % 4) == 0, pay(32'hD0 + k));
            k++;
         end
      end
      chk("t4_beats", k, 8);
      chk("t4_unfull", flow_full_out, 4'b0000);

      // flows 0 and 1 both holding full batches: service alternates
      l_tx_batch_size = 2'd1;
      number_of_flows = 2'd1;
      sRx_c1TxAlmFull = 1'b1;
      for (int i = 0; i < 4; i++) push(2'd0, pay(32'h500 + i));
      for (int i = 0; i < 4; i++) push(2'd1, pay(32'h510 + i));
      sRx_c1TxAlmFull = 1'b0;
      k = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (tx.valid) begin
            if (k < 8) begin
               fl = ef[k];
               ix = ei[k];
               chk_beat($sformatf("t5_b%0d", k),
                        BASE + t_ccip_clAddr'(fl * 2 + (k % 2)), eCL_LEN_2,
                        (k % 2) == 0, pay(32'h500 + fl * 16 + ix));
            end
            k++;
         end
      end
      chk("t5_beats", k, 8);

      // reset during a 4-beat batch, then normal operation resumes
      l_tx_batch_size = 2'd2;
      number_of_flows = 2'd3;
      for (int i = 0; i < 4; i++) push(2'd1, pay(32'hE0 + i));
      wait_valid("t6", 12, cyc);
      chk_beat("t6_b0", BASE + 42'h4, eCL_LEN_4, 1'b1, pay(32'hE0));
      step();
      chk_beat("t6_b1", BASE + 42'h5, eCL_LEN_4, 1'b0, pay(32'hE1));
      reset_n = 1'b0;
      step();
      chk("t6_rst_valid", tx.valid, 1'b0);
      chk("t6_rst_pdrop", pdrop_cnt_out, 32'd0);
      chk("t6_rst_flush", flush_cnt_out, 32'd0);
      chk("t6_rst_full", flow_full_out, 4'b0000);
      step();
      reset_n = 1'b1;
      quiet("t6_quiet", 6);
      for (int i = 0; i < 4; i++) push(2'd1, pay(32'hF0 + i));
      wait_valid("t6n", 12, cyc);
      chk_beat("t6n_b0", BASE + 42'h4, eCL_LEN_4, 1'b1, pay(32'hF0));
      for (int i = 1; i < 4; i++) begin
         step();
         chk_beat($sformatf("t6n_b%0d", i), BASE + 42'h4 + t_ccip_clAddr'(i),
                  eCL_LEN_4, 1'b0, pay(32'hF0 + i));
      end
      quiet("t6n_idle", 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
